// File: rtl/kbd_seq_ctrl.sv
// PS/2 scancode sequencer: decodes make/break/E0 prefixes, looks up ASCII and counts key presses.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses counting of typematic repeats of the held key.
module kbd_seq_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             ret,
   input  logic             code_valid,
   input  logic [7:0]       code,
   output logic             code_ready,
   output logic [7:0]       lut_addr,
   input  logic [7:0]       lut_data,
   output logic [7:0]       cur_scan,
   output logic [7:0]       cur_asc,
   output logic             ext_key,
   output logic             key_down,
   output logic             key_evt,
   output logic [CNT_W-1:0] press_cnt
);

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GOT_F0   = 3'd1,
      GOT_E0   = 3'd2,
      GOT_E0F0 = 3'd3,
      LOOKUP   = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [7:0]       lut_addr_reg;
   logic [7:0]       cur_scan_reg;
   logic [7:0]       cur_asc_reg;
   logic             ext_reg;
   logic             ext_key_reg;
   logic             key_down_reg;
   logic             key_evt_reg;
   logic [CNT_W-1:0] press_cnt_reg;
   logic             ready_next;
   logic             xfer;
   logic             count_en;
   logic             brk_match;

   assign xfer = code_valid & ready_next;

   // A break only releases the key if both the scancode and the E0 prefix agree.
   assign brk_match = (code == cur_scan_reg) && (ext_key_reg == (state_reg == GOT_E0F0));

`ifdef KBD_TYPEMATIC_FILTER_EN
   assign count_en = !(key_down_reg && (lut_addr_reg == cur_scan_reg) && (ext_reg == ext_key_reg));
`else
   assign count_en = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (ret) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (xfer) begin
               if (code == BRK_CODE) begin
                  state_next = GOT_F0;
               end else if (code == EXT_CODE) begin
                  state_next = GOT_E0;
               end else begin
                  state_next = LOOKUP;
               end
            end
         end
         GOT_E0: begin
            if (xfer) begin
               state_next = (code == BRK_CODE) ? GOT_E0F0 : LOOKUP;
            end
         end
         GOT_F0, GOT_E0F0: begin
            if (xfer) begin
               state_next = IDLE;
            end
         end
         LOOKUP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready is gated by reset so no byte is accepted during the reset cycle.
   always_comb begin
      ready_next = 1'b0;
      if (!ret && (state_reg != LOOKUP)) begin
         ready_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ret) begin
         lut_addr_reg  <= '0;
         cur_scan_reg  <= '0;
         cur_asc_reg   <= '0;
         ext_reg       <= 1'b0;
         ext_key_reg   <= 1'b0;
         key_down_reg  <= 1'b0;
         key_evt_reg   <= 1'b0;
         press_cnt_reg <= '0;
      end else begin
         key_evt_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (xfer && (code != BRK_CODE) && (code != EXT_CODE)) begin
                  lut_addr_reg <= code;
                  ext_reg      <= 1'b0;
               end
            end
            GOT_E0: begin
               if (xfer && (code != BRK_CODE)) begin
                  lut_addr_reg <= code;
                  ext_reg      <= 1'b1;
               end
            end
            GOT_F0, GOT_E0F0: begin
               if (xfer && brk_match) begin
                  key_down_reg <= 1'b0;
               end
            end
            LOOKUP: begin
               cur_scan_reg <= lut_addr_reg;
               cur_asc_reg  <= ext_reg ? 8'h00 : lut_data;
               ext_key_reg  <= ext_reg;
               key_down_reg <= 1'b1;
               if (count_en) begin
                  press_cnt_reg <= press_cnt_reg + CNT_W'(1);
                  key_evt_reg   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign code_ready = ready_next;
   assign lut_addr   = lut_addr_reg;
   assign cur_scan   = cur_scan_reg;
   assign cur_asc    = cur_asc_reg;
   assign ext_key    = ext_key_reg;
   assign key_down   = key_down_reg;
   assign key_evt    = key_evt_reg;
   assign press_cnt  = press_cnt_reg;

endmodule

// File: tb/tb_kbd_seq_ctrl.sv
// Directed bench for kbd_seq_ctrl: protocol model plus key-event scoreboard queue.
module tb_kbd_seq_ctrl;

   localparam int CNT_W = 8;

   logic             clk;
   logic             ret;
   logic             code_valid;
   logic [7:0]       code;
   logic             code_ready;
   logic [7:0]       lut_addr;
   logic [7:0]       lut_data;
   logic [7:0]       cur_scan;
   logic [7:0]       cur_asc;
   logic             ext_key;
   logic             key_down;
   logic             key_evt;
   logic [CNT_W-1:0] press_cnt;

   logic [7:0] lut_mem [256];

   typedef struct packed {
      logic [7:0]       scan;
      logic [7:0]       asc;
      logic [CNT_W-1:0] cnt;
   } evt_t;

   evt_t evt_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // bench-side model of the visible controller state
   int               m_st;
   logic [7:0]       m_addr;
   logic [7:0]       m_scan;
   logic [7:0]       m_asc;
   logic             m_ext;
   logic             m_down;
   logic [CNT_W-1:0] m_cnt;

   kbd_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .ret(ret), .code_valid(code_valid), .code(code),
      .code_ready(code_ready), .lut_addr(lut_addr), .lut_data(lut_data),
      .cur_scan(cur_scan), .cur_asc(cur_asc), .ext_key(ext_key),
      .key_down(key_down), .key_evt(key_evt), .press_cnt(press_cnt)
   );

   assign lut_data = lut_mem[lut_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // key_evt pulses are matched against queued expected make events
   always @(negedge clk) begin
      if (!ret && key_evt === 1'b1) begin
         if (evt_q.size() == 0) begin
            chk("evt_unexpected", 32'd1, 32'd0);
         end else begin
            evt_t e;
            e = evt_q.pop_front();
            chk("evt_scan", {24'd0, cur_scan}, {24'd0, e.scan});
            chk("evt_asc", {24'd0, cur_asc}, {24'd0, e.asc});
            chk("evt_cnt", 32'(press_cnt), 32'(e.cnt));
            $display("evt scan=%02h asc=%02h cnt=%0d", cur_scan, cur_asc, press_cnt);
         end
      end
   end

   task automatic model_make(input logic [7:0] b, input logic ext);
      logic counted;
      counted = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
      if (m_down && b == m_scan && ext == m_ext) counted = 1'b0;
`endif
      m_addr = b;
      m_scan = b;
      m_asc  = ext ? 8'h00 : lut_mem[b];
      m_ext  = ext;
      m_down = 1'b1;
      if (counted) begin
         m_cnt = m_cnt + 1'b1;
         evt_q.push_back('{scan: b, asc: m_asc, cnt: m_cnt});
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      case (m_st)
         0: if (b == 8'hF0) m_st = 1; else if (b == 8'hE0) m_st = 2;
            else begin model_make(b, 1'b0); m_st = 0; end
         2: if (b == 8'hF0) m_st = 3; else begin model_make(b, 1'b1); m_st = 0; end
         default: begin
            if (b == m_scan && m_ext == (m_st == 3)) m_down = 1'b0;
            m_st = 0;
         end
      endcase
   endtask

   // called at a negedge; returns at the negedge following the transfer edge
   task automatic send(input logic [7:0] b);
      int n;
      code_valid = 1'b1;
      code = b;
      n = 0;
      while (code_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      code_valid = 1'b0;
      model_byte(b);
      $display("send %02h", b);
   endtask

   task automatic check_all(input string tag);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_scan"}, {24'd0, cur_scan}, {24'd0, m_scan});
      chk({tag, "_asc"}, {24'd0, cur_asc}, {24'd0, m_asc});
      chk({tag, "_ext"}, {31'd0, ext_key}, {31'd0, m_ext});
      chk({tag, "_down"}, {31'd0, key_down}, {31'd0, m_down});
      chk({tag, "_cnt"}, 32'(press_cnt), 32'(m_cnt));
      chk({tag, "_addr"}, {24'd0, lut_addr}, {24'd0, m_addr});
      $display("%s scan=%02h asc=%02h ext=%0b down=%0b cnt=%0d", tag, cur_scan, cur_asc,
               ext_key, key_down, press_cnt);
   endtask

   // reset with a byte offered: reset must win over the transfer
   task automatic do_reset(input int cycles);
      ret = 1'b1;
      code_valid = 1'b1;
      code = 8'h1C;
      for (int i = 0; i < cycles; i++) @(negedge clk);
      chk("rst_ready", {31'd0, code_ready}, 32'd0);
      chk("rst_outs", {lut_addr, cur_scan, cur_asc, 8'(press_cnt)}, 32'd0);
      chk("rst_flags", {29'd0, ext_key, key_down, key_evt}, 32'd0);
      ret = 1'b0;
      code_valid = 1'b0;
      m_st = 0; m_addr = 0; m_scan = 0; m_asc = 0; m_ext = 0; m_down = 0; m_cnt = 0;
      evt_q.delete();
      @(negedge clk);
      chk("rst_ready_after", {31'd0, code_ready}, 32'd1);
      $display("reset done");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) lut_mem[i] = 8'(i) ^ 8'h5A;
      lut_mem[8'h1C] = 8'h41;
      lut_mem[8'h32] = 8'h42;
      lut_mem[8'h75] = 8'h99;
      ret = 1'b1;
      code_valid = 1'b0;
      code = 8'h00;
      @(negedge clk);
      do_reset(2);

      // single make: ready drops for exactly the LOOKUP cycle
      send(8'h1C);
      chk("lookup_ready", {31'd0, code_ready}, 32'd0);
      @(negedge clk);
      chk("post_ready", {31'd0, code_ready}, 32'd1);
      chk("evt_pulse", {31'd0, key_evt}, 32'd1);
      chk("cnt_one", 32'(press_cnt), 32'd1);
      check_all("make1c");

      send(8'hF0); send(8'h1C);
      check_all("break1c");
      send(8'hF0); send(8'h32);
      check_all("nomatch_brk");

      do_reset(1);
      send(8'h1C); send(8'h1C); send(8'h1C);
      check_all("typematic");

      send(8'hE0); send(8'h75);
      check_all("ext_make");
      send(8'hF0); send(8'h75);
      check_all("ext_plainbrk");
      send(8'hE0); send(8'hF0); send(8'h75);
      check_all("ext_brk");

      do_reset(1);
      for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
      check_all("cnt_255");
      send(8'h1C);
      check_all("cnt_wrap");

      send(8'hF0);
      do_reset(1);
      send(8'h1C);
      check_all("rst_midseq");

      repeat (3) @(negedge clk);
      chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
